// File: rtl/traffic_action_decider_pkg.sv
// Shared types and constants for the traffic action decider.
// Lane levels are packed LVL_W bits per lane, lane 0 in the LSBs.
package traffic_pkg;

  localparam int LVL_W   = 3;
  localparam int N_LANES = 4;
  localparam int STATE_W = N_LANES * LVL_W;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_ISSUE  = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_t;

  typedef logic [1:0]              action_t;
  typedef logic [LVL_W-1:0]        lvl_t;
  typedef lvl_t [N_LANES-1:0]      lvls_t;

  function automatic lvls_t unpack_levels(input logic [STATE_W-1:0] word);
    lvls_t lv;
    for (int i = 0; i < N_LANES; i++) begin
      lv[i] = word[i*LVL_W +: LVL_W];
    end
    return lv;
  endfunction

endpackage

// File: rtl/traffic_action_decider_if.sv
// State-word / action handshake bundle between environment and decider.
// master = environment side, slave = decider side.
interface traffic_action_decider_if;
  import traffic_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [STATE_W-1:0] s_state;
  action_t            action;
  logic               action_valid;
  logic               action_ready;
  phase_t             phase;

  modport master (
    output s_valid, s_state, action_ready,
    input  s_ready, action, action_valid, phase
  );

  modport slave (
    input  s_valid, s_state, action_ready,
    output s_ready, action, action_valid, phase
  );

endinterface

// File: rtl/traffic_action_decider_lane_argmax.sv
// Combinational argmax over the lane levels with an exclude mask.
// Ties resolve to the lowest lane index; excluded lanes are never chosen.
module lane_argmax
  import traffic_pkg::*;
(
  input  lvls_t                lvls_i,
  input  logic [N_LANES-1:0]   excl_i,
  output action_t              idx_o,
  output lvl_t                 lvl_o
);

  logic found;

  always_comb begin
    idx_o = '0;
    lvl_o = '0;
    found = 1'b0;
    // Strict '>' keeps the earliest lane on ties.
    for (int i = 0; i < N_LANES; i++) begin
      if (!excl_i[i] && (!found || (lvls_i[i] > lvl_o))) begin
        idx_o = action_t'(i);
        lvl_o = lvls_i[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_action_decider.sv
// Greedy green-lane decider with min/max green and yellow interval.
// Optional exploration LFSR enabled by defining TRAFFIC_EXPLORE_EN.
//
// state     | meaning
// IDLE      | waiting for the first state word
// ISSUE     | action offered, waiting for action_ready
// GREEN     | lane active; accepts words once cnt >= MIN_GREEN
// YELLOW    | transition interval before issuing the next lane
module traffic_action_decider
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_action_decider_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_GREEN + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] CNT_YEL = CNT_W'(YELLOW - 1);

  phase_t            state_q, state_d;
  action_t           action_q, action_d;
  action_t           next_q, next_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  lvls_t             lvls;
  action_t           best_idx, second_idx, cand;
  lvl_t              best_lvl, second_lvl;
  logic              all_zero;
  logic              s_ready_c;
  logic              action_valid_c;
  logic [N_LANES-1:0] excl_cur;

  assign lvls     = unpack_levels(bus.s_state);
  assign excl_cur = N_LANES'(1) << action_q;

  lane_argmax u_best (
    .lvls_i (lvls),
    .excl_i ('0),
    .idx_o  (best_idx),
    .lvl_o  (best_lvl)
  );

  lane_argmax u_second (
    .lvls_i (lvls),
    .excl_i (excl_cur),
    .idx_o  (second_idx),
    .lvl_o  (second_lvl)
  );

  // The largest level is zero only when every lane is empty.
  assign all_zero = (best_lvl == '0);

`ifdef TRAFFIC_EXPLORE_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  assign cand = (lfsr_q[3:0] == 4'h0) ? lfsr_q[5:4] : best_idx;
`else
  assign cand = best_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PH_IDLE;
      action_q <= '0;
      next_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      action_q <= action_d;
      next_q   <= next_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    action_d       = action_q;
    next_d         = next_q;
    cnt_d          = cnt_q;
    s_ready_c      = 1'b0;
    action_valid_c = 1'b0;

    unique case (state_q)
      PH_IDLE: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          action_d = cand;
          state_d  = PH_ISSUE;
        end
      end

      PH_ISSUE: begin
        action_valid_c = 1'b1;
        if (bus.action_ready) begin
          state_d = PH_GREEN;
          cnt_d   = '0;
        end
      end

      PH_GREEN: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        s_ready_c = (cnt_q >= CNT_MIN);
        if (s_ready_c && bus.s_valid && !all_zero) begin
          if (cand != action_q) begin
            next_d  = cand;
            state_d = PH_YELLOW;
            cnt_d   = '0;
          end else if ((cnt_q == CNT_MAX) && (second_lvl != '0)) begin
            // Green exhausted: hand over to the runner-up lane.
            next_d  = second_idx;
            state_d = PH_YELLOW;
            cnt_d   = '0;
          end
        end
      end

      PH_YELLOW: begin
        if (cnt_q == CNT_YEL) begin
          action_d = next_q;
          state_d  = PH_ISSUE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = PH_IDLE;
    endcase
  end

  assign bus.s_ready      = s_ready_c & ~rst;
  assign bus.action_valid = action_valid_c;
  assign bus.action       = action_q;
  assign bus.phase        = state_q;

endmodule

// File: tb/tb_traffic_action_decider.sv
// Directed self-checking bench for traffic_action_decider (default greedy build).
module tb_traffic_action_decider;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  traffic_action_decider_if bus ();

  traffic_action_decider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset, accept word w in IDLE, hand-shake; returns at the negedge with GREEN, cnt=0.
  task automatic go_green(input logic [11:0] w);
    bus.s_valid      = 1'b0;
    bus.action_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_state = w;
    @(negedge clk);
    bus.s_valid      = 1'b0;
    bus.action_ready = 1'b1;
    @(negedge clk);
    bus.action_ready = 1'b0;
    chk("go_green_phase", 32'(bus.phase), 32'd2);
  endtask

  initial begin
    rst              = 1'b1;
    bus.s_valid      = 1'b0;
    bus.s_state      = '0;
    bus.action_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_phase",  32'(bus.phase),        32'd0);
    chk("rst_action", 32'(bus.action),       32'd0);
    chk("rst_valid",  32'(bus.action_valid), 32'd0);
    chk("rst_sready", 32'(bus.s_ready),      32'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("idle_sready", 32'(bus.s_ready), 32'd1);

    // IDLE accept of L2=3, held offer, then handshake
    bus.s_valid = 1'b1;
    bus.s_state = 12'h0C0;
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("issue_phase",  32'(bus.phase),        32'd1);
    chk("issue_action", 32'(bus.action),       32'd2);
    chk("issue_valid",  32'(bus.action_valid), 32'd1);
    chk("issue_sready", 32'(bus.s_ready),      32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_action", 32'(bus.action),       32'd2);
      chk("hold_valid",  32'(bus.action_valid), 32'd1);
    end
    bus.action_ready = 1'b1;
    @(negedge clk);
    bus.action_ready = 1'b0;
    chk("green_phase", 32'(bus.phase),        32'd2);
    chk("green_valid", 32'(bus.action_valid), 32'd0);

    // Switch to L1=7 after min green, yellow interval, then re-issue
    chk("mg_sready_c0", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_state = 12'h038;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("mg_sready_low", 32'(bus.s_ready), 32'd0);
    end
    @(negedge clk);
    chk("mg_sready_c4", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("yel1_phase",  32'(bus.phase),  32'd3);
    chk("yel1_action", 32'(bus.action), 32'd2);
    @(negedge clk);
    chk("yel2_phase",  32'(bus.phase),  32'd3);
    chk("yel2_action", 32'(bus.action), 32'd2);
    @(negedge clk);
    chk("sw_phase",  32'(bus.phase),        32'd1);
    chk("sw_action", 32'(bus.action),       32'd1);
    chk("sw_valid",  32'(bus.action_valid), 32'd1);

    // Tie from IDLE: L0=L1=L2=7 picks lane 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_state = 12'h1FF;
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("tie_action", 32'(bus.action),       32'd0);
    chk("tie_valid",  32'(bus.action_valid), 32'd1);

    // Max green: L2=7, L0=1 held; switch to lane 0 only at cnt=16
    go_green(12'h0C0);
    bus.s_valid = 1'b1;
    bus.s_state = 12'h1C1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("maxg_stay", 32'(bus.phase), 32'd2);
    end
    @(negedge clk);
    chk("maxg_yel_phase",  32'(bus.phase),  32'd3);
    chk("maxg_yel_action", 32'(bus.action), 32'd2);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("maxg_yel2_phase", 32'(bus.phase), 32'd3);
    @(negedge clk);
    chk("maxg_iss_phase",  32'(bus.phase),  32'd1);
    chk("maxg_iss_action", 32'(bus.action), 32'd0);

    // Max green with no runner-up: stays on lane 2
    go_green(12'h0C0);
    bus.s_valid = 1'b1;
    bus.s_state = 12'h1C0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      chk("solo_phase",  32'(bus.phase),  32'd2);
      chk("solo_action", 32'(bus.action), 32'd2);
    end
    bus.s_valid = 1'b0;

    // All-zero word in GREEN: accepted, no yellow
    go_green(12'h0C0);
    bus.s_valid = 1'b1;
    bus.s_state = 12'h000;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("zero_phase",  32'(bus.phase),  32'd2);
      chk("zero_action", 32'(bus.action), 32'd2);
    end
    chk("zero_sready", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b0;

    // Reset during YELLOW
    go_green(12'h0C0);
    bus.s_valid = 1'b1;
    bus.s_state = 12'h038;
    repeat (5) @(negedge clk);
    bus.s_valid = 1'b0;
    chk("rstY_pre_phase", 32'(bus.phase), 32'd3);
    rst = 1'b1;
    chk("rstY_sready_hi", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    chk("rstY_phase",  32'(bus.phase),        32'd0);
    chk("rstY_action", 32'(bus.action),       32'd0);
    chk("rstY_valid",  32'(bus.action_valid), 32'd0);
    chk("rstY_sready", 32'(bus.s_ready),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstY_rel_sready", 32'(bus.s_ready), 32'd1);
    chk("rstY_rel_phase",  32'(bus.phase),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_action_decider.md
Name: traffic_action_decider

Overview:
- Consumer end of the traffic state interface: accepts a packed 12-bit lane-state word and issues the green-lane action (2-bit lane index) back to the environment / state converter.
- Greedy policy: pick the lane with the highest queue level, subject to minimum green, maximum green and a yellow interval.
- One instance per intersection (A and B are instantiated separately).

Parameters:
- LVL_W, 3, bits per lane level (fixed at 3 for the 12-bit word).
- MIN_GREEN, 4, cycles in GREEN before a new state word is accepted.
- MAX_GREEN, 16, GREEN cycles after which the current lane may not be re-selected.
- YELLOW, 2, cycles spent in YELLOW between two different actions.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  state word valid
- s_ready  out  1  decider can accept a state word
- s_state  in  12  packed levels: L0=[2:0], L1=[5:3], L2=[8:6], L3=[11:9]
- action  out  2  current/next green lane index
- action_valid  out  1  new action offered
- action_ready  in  1  environment takes the action
- phase  out  2  0=IDLE, 1=ISSUE, 2=GREEN, 3=YELLOW

Behaviour:
- Reset values:
  - State=IDLE, action=0, action_valid=0, phase=0, counter=0.
  - s_ready=0 while rst is high.
- s_ready (combinational):
  - 1 in IDLE.
  - 1 in GREEN when cnt >= MIN_GREEN.
  - 0 otherwise.
- Accept: a state word is taken on s_valid && s_ready. The decision is computed the same cycle from s_state.
- Argmax rule:
  - best = lane with the largest level; ties go to the lowest index.
  - second = argmax with the current lane excluded, same tie rule.
- IDLE:
  - On accept: action <= best, go to ISSUE.
  - An all-zero word still selects lane 0.
- ISSUE:
  - action_valid=1; action is held stable.
  - On action_ready: go to GREEN, cnt <= 0, action_valid drops next cycle.
- GREEN:
  - cnt increments every cycle and saturates at MAX_GREEN.
  - Counter width is clog2(MAX_GREEN+1).
  - On accept, in priority order:
    - All levels 0: stay in GREEN, cnt keeps counting.
    - best != action: next <= best, go to YELLOW.
    - best == action and cnt < MAX_GREEN: stay (extend green).
    - best == action and cnt == MAX_GREEN: if second's level > 0, next <= second and go to YELLOW; else stay.
- YELLOW:
  - cnt counts 0..YELLOW-1.
  - Then action <= next, go to ISSUE.
  - action keeps the old lane during YELLOW.
- Latency:
  - IDLE accept to action_valid: 1 cycle.
  - GREEN switch to action_valid: YELLOW+1 cycles.
- Simultaneous events:
  - s_valid is ignored outside the ready windows (no buffering).
  - action_ready is ignored outside ISSUE.
- rst mid-operation (any state): next cycle returns to IDLE with reset values; a pending action is dropped without a handshake.

Optional Feature:
- Macro TRAFFIC_EXPLORE_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle.
  - At each accept decision, if lfsr[3:0]==4'h0, the candidate lane is lfsr[5:4] instead of best.
  - All other rules still apply: min/max green, yellow when the lane differs, the all-zero stay rule.
- Undefined: no LFSR logic; purely greedy.

Decomposition:
- traffic_pkg holds:
  - LVL_W, N_LANES=4, STATE_W=12
  - phase_t enum (IDLE/ISSUE/GREEN/YELLOW)
  - action_t (2-bit)
  - level-unpack function for the 12-bit word
- Sub-module lane_argmax (combinational):
  - Inputs: 4 levels, exclude mask.
  - Outputs: index and max level, lowest-index tie-break.
  - Instantiated twice (best, second).

Test Plan:
- Reset, then s_state=12'h0C0 (L2=3): accepted in IDLE; action=2, action_valid=1 next cycle; hold action_ready=0 for 3 cycles, so action stays 2 and valid stays high; assert ready, so phase=GREEN.
- In GREEN on lane 2, hold s_valid with 12'h038 (L1=7): s_ready low for 4 cycles, accept at cnt=4; phase=YELLOW for 2 cycles with action still 2; then ISSUE with action=1.
- Tie check from IDLE with 12'h1FF (L0=L1=L2=7): action=0.
- GREEN on lane 2, feed 12'h1C1 (L2=7, L0=1) continuously: stays GREEN until cnt=16; the next accept gives YELLOW then action=0. Repeat with 12'h1C0: stays on lane 2 indefinitely.
- GREEN, feed 12'h000 after min green: accepted, no YELLOW, phase stays GREEN, action unchanged.
- Assert rst during YELLOW: next cycle phase=0, action=0, action_valid=0, s_ready=0 while rst is high and 1 after release.
